// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg: shared EX-stage definitions for control fields, ALU ops, FSM states and multiplier sizing.
package execute_stage_pkg;
  localparam int CTRL_EX_W = 12;
  localparam int CTRL_MEM_W = 8;
  localparam int CE_C_SEL = 11;
  localparam int CE_D_SEL = 10;
  localparam int CE_OP_LSB = 8;
  localparam int MUL_CNT_W = 5;
  localparam logic [CTRL_MEM_W-1:0] CTRL_MEM_NOP = 8'h80;
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_e;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_MUL_DONE = 2'd2
  } ex_state_e;
  function automatic logic [31:0] alu_op(input op_e op, input logic [31:0] a, input logic [31:0] c);
    return op == OP_ADD ? a + c : op == OP_SUB ? a - c : op == OP_AND ? a & c : a | c;
  endfunction
  // Index of the final iteration for a multiplier retiring `step` bits per cycle.
  function automatic logic [MUL_CNT_W-1:0] mul_last(input int step);
    return MUL_CNT_W'(32 / step - 1);
  endfunction
endpackage

// File: rtl/execute_stage_seq_multiplier.sv
// seq_multiplier: iterative 32x32 -> low-32 multiplier retiring MUL_STEP multiplier bits per cycle.
module seq_multiplier
  import execute_stage_pkg::*;
#(
  parameter int MUL_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_a,
  input  logic [31:0] i_c,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_product
);
  localparam logic [MUL_CNT_W-1:0] LAST = mul_last(MUL_STEP);
  logic [31:0]          r_a;
  logic [31:0]          r_c;
  logic [31:0]          r_acc;
  logic [MUL_CNT_W-1:0] r_cnt;
  logic                 r_busy;
  logic [31:0]          w_pp;
  // Multiplicand shifts left and multiplier right each step, so bit k of r_c always weights r_a << k.
  always_comb begin
    w_pp = '0;
    for (int k = 0; k < MUL_STEP; k++) w_pp = w_pp + (r_c[k] ? (r_a << k) : 32'd0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_c    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_abort) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_a    <= i_a;
      r_c    <= i_c;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc  <= r_acc + w_pp;
      r_a    <= r_a << MUL_STEP;
      r_c    <= r_c >> MUL_STEP;
      r_cnt  <= r_cnt + 1'b1;
      r_busy <= r_cnt != LAST;
    end
  end
  assign o_busy    = r_busy;
  assign o_done    = r_busy & (r_cnt == LAST);
  assign o_product = r_acc;
endmodule

// File: rtl/execute_stage.sv
// execute_stage: EX pipeline stage with one-cycle ALU, iterative MUL and a valid/ready result register to MEM.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int MUL_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [CTRL_EX_W-1:0]  i_ctrl_ex,
  input  logic [31:0]           i_a_val,
  input  logic [31:0]           i_b_val,
  input  logic [31:0]           i_imm,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [31:0]           o_d_out,
  output logic [31:0]           o_m_wdata,
  output logic [CTRL_MEM_W-1:0] o_ctrl_mem
);
  ex_state_e             r_state;
  logic                  r_out_valid;
  logic [31:0]           r_d_out;
  logic [31:0]           r_m_wdata;
  logic [CTRL_MEM_W-1:0] r_ctrl_mem;
  logic [31:0]           r_mul_wdata;
  logic [CTRL_MEM_W-1:0] r_mul_ctrl;
  logic [31:0]           w_c;
  logic [31:0]           w_alu;
  logic [31:0]           w_product;
  logic                  w_out_free;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_alu_sel;
  logic                  w_mul_busy;
  logic                  w_mul_done;
  assign w_c        = i_ctrl_ex[CE_C_SEL] ? i_imm : i_b_val;
  assign w_alu      = alu_op(op_e'(i_ctrl_ex[CE_OP_LSB +: 2]), i_a_val, w_c);
  assign w_alu_sel  = i_ctrl_ex[CE_D_SEL];
  assign w_out_free = ~r_out_valid | i_out_ready;
  assign w_in_ready = (r_state == ST_IDLE) & ~i_flush & w_out_free;
  assign w_accept   = i_in_valid & w_in_ready;
  seq_multiplier #(.MUL_STEP(MUL_STEP)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_accept & ~w_alu_sel),
    .i_abort   (i_flush),
    .i_a       (i_a_val),
    .i_c       (w_c),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_d_out     <= '0;
      r_m_wdata   <= '0;
      r_ctrl_mem  <= CTRL_MEM_NOP;
      r_mul_wdata <= '0;
      r_mul_ctrl  <= CTRL_MEM_NOP;
    end else if (i_flush) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_d_out     <= '0;
      r_m_wdata   <= '0;
      r_ctrl_mem  <= CTRL_MEM_NOP;
    end else begin
      // A load later in this block overrides the drain, keeping back-to-back throughput.
      if (i_out_ready) r_out_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept && w_alu_sel) begin
            r_d_out     <= w_alu;
            r_m_wdata   <= i_b_val;
            r_ctrl_mem  <= i_ctrl_ex[CTRL_MEM_W-1:0];
            r_out_valid <= 1'b1;
          end else if (w_accept) begin
            r_mul_wdata <= i_b_val;
            r_mul_ctrl  <= i_ctrl_ex[CTRL_MEM_W-1:0];
            r_state     <= ST_MUL_BUSY;
          end
        end
        ST_MUL_BUSY: r_state <= w_mul_done ? ST_MUL_DONE : w_mul_busy ? ST_MUL_BUSY : ST_IDLE;
        ST_MUL_DONE: begin
          if (w_out_free) begin
            r_d_out     <= w_product;
            r_m_wdata   <= r_mul_wdata;
            r_ctrl_mem  <= r_mul_ctrl;
            r_out_valid <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_d_out     = r_d_out;
  assign o_m_wdata   = r_m_wdata;
  assign o_ctrl_mem  = r_ctrl_mem;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: table vectors, hand-written multi-cycle sequences and a randomized scoreboard run.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] ctrl_ex = '0;
  logic [31:0] a_val = '0;
  logic [31:0] b_val = '0;
  logic [31:0] imm = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] d_out;
  logic [31:0] m_wdata;
  logic [7:0]  ctrl_mem;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  execute_stage #(.MUL_STEP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_ctrl_ex  (ctrl_ex),
    .i_a_val    (a_val),
    .i_b_val    (b_val),
    .i_imm      (imm),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_d_out    (d_out),
    .o_m_wdata  (m_wdata),
    .o_ctrl_mem (ctrl_mem)
  );

  typedef struct {
    logic [11:0] ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] d;
    logic [31:0] w;
    logic [7:0]  cm;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [31:0] w;
    logic [7:0]  cm;
  } exp_t;

  vec_t vt[10];
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] mk(input bit cs, input bit ds, input bit [1:0] op, input bit wr,
                                     input bit ws, input bit we, input bit [4:0] rg);
    return {cs, ds, op, wr, ws, we, rg};
  endfunction

  function automatic logic [31:0] ref_res(input logic [11:0] ct, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] im);
    logic [31:0] c;
    c = ct[11] ? im : b;
    if (!ct[10]) return a * c;
    case (ct[9:8])
      2'd0:    return a + c;
      2'd1:    return a - c;
      2'd2:    return a & c;
      default: return a | c;
    endcase
  endfunction

  task automatic run_one(input vec_t v, input string nm);
    int n;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    ctrl_ex = v.ctrl; a_val = v.a; b_val = v.b; imm = v.imm;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
    check({nm, "_accept"}, 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0; ctrl_ex = $urandom; a_val = $urandom; b_val = $urandom; imm = $urandom;
    #1;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); #1; n++; end
    check({nm, "_valid"}, 32'(out_valid), 1);
    check({nm, "_d_out"}, d_out, v.d);
    check({nm, "_m_wdata"}, m_wdata, v.w);
    check({nm, "_ctrl_mem"}, 32'(ctrl_mem), 32'(v.cm));
  endtask

  task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    ctrl_ex = mk(0, 0, 0, 1, 0, 1, 5'd12); a_val = a; b_val = b;
    #1;
    check("mul_start_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] prev;
    logic [31:0] pd, pw;
    logic [7:0]  pc;
    exp_t e;
    int lat, low, seen;
    bit held;

    vt[0] = '{mk(0, 1, 0, 0, 1, 1, 3), 32'd5, 32'd7, 32'd0, 32'd12, 32'd7, 8'h63};
    vt[1] = '{mk(0, 1, 1, 1, 0, 1, 4), 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 8'hA4};
    vt[2] = '{mk(0, 1, 2, 1, 0, 1, 5), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'h00F0_00F0, 32'h0FF0_0FF0, 8'hA5};
    vt[3] = '{mk(0, 1, 3, 1, 0, 1, 6), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 8'hA6};
    vt[4] = '{mk(1, 1, 0, 0, 0, 0, 0), 32'd100, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'd96, 32'hDEAD_BEEF, 8'h00};
    vt[5] = '{mk(1, 1, 0, 1, 1, 1, 7), 32'd100, 32'd0, 32'd8, 32'd108, 32'd0, 8'hE7};
    vt[6] = '{mk(0, 0, 0, 0, 0, 1, 8), 32'd12345, 32'd678, 32'd0, 32'd8369910, 32'd678, 8'h28};
    vt[7] = '{mk(0, 0, 0, 1, 0, 1, 9), 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFE, 32'd2, 8'hA9};
    vt[8] = '{mk(1, 0, 0, 1, 0, 1, 10), 32'hFFFF_FFFD, 32'h55, 32'd7, 32'hFFFF_FFEB, 32'h55, 8'hAA};
    vt[9] = '{mk(0, 1, 0, 1, 0, 0, 0), 32'd1, 32'd1, 32'd0, 32'd2, 32'd1, 8'h80};

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_d_out", d_out, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_ctrl_mem", 32'(ctrl_mem), 32'h80);
    check("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_one(vt[i], $sformatf("vec%0d", i));

    // MUL latency and stall of decode
    start_mul(32'd12345, 32'd678);
    a_val = $urandom; b_val = $urandom;
    #1;
    lat = 1; low = 0;
    while (!out_valid && lat < 20) begin
      if (!in_ready) low++;
      @(negedge clk); #1; lat++;
    end
    check("mul_in_ready_low", 32'(low >= 8 && low <= 9), 1);
    check("mul_latency", 32'(lat >= 9 && lat <= 10), 1);
    check("mul_d_out", d_out, 32'd8369910);
    @(negedge clk); #1;
    check("mul_drained", 32'(out_valid), 0);

    // Backpressure: held output, stalled decode, release gives one transfer then a new accept
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; ctrl_ex = mk(0, 1, 0, 1, 0, 1, 1); a_val = 10; b_val = 20;
    @(negedge clk);
    a_val = 1; b_val = 1;
    #1;
    repeat (3) begin
      check("bp_valid", 32'(out_valid), 1);
      check("bp_d_hold", d_out, 30);
      check("bp_wdata_hold", m_wdata, 20);
      check("bp_ready", 32'(in_ready), 0);
      @(negedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("bp_next_valid", 32'(out_valid), 1);
    check("bp_next_d", d_out, 2);
    @(negedge clk); #1;
    check("bp_empty", 32'(out_valid), 0);

    // Back-to-back ALU throughput
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      ctrl_ex = mk(0, 1, 0, 1, 0, 1, 5'(i)); a_val = 32'(i * 3 + 1); b_val = 100;
      #1;
      check("tp_ready", 32'(in_ready), 1);
      if (i > 0) begin
        check("tp_valid", 32'(out_valid), 1);
        check("tp_d", d_out, prev);
      end
      prev = ref_res(ctrl_ex, a_val, b_val, imm);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("tp_last_valid", 32'(out_valid), 1);
    check("tp_last_d", d_out, prev);

    // Flush of a held output
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; ctrl_ex = mk(0, 1, 0, 0, 0, 1, 2); a_val = 3; b_val = 4;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("fh_valid_before", 32'(out_valid), 1);
    flush = 1'b1;
    #1;
    check("fh_ready", 32'(in_ready), 0);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1;
    #1;
    check("fh_valid_after", 32'(out_valid), 0);
    check("fh_ctrl_mem", 32'(ctrl_mem), 32'h80);

    // Flush in the third multiply cycle, with a competing instruction offered
    start_mul(32'd99, 32'd77);
    repeat (2) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; ctrl_ex = mk(0, 1, 0, 1, 0, 1, 3); a_val = 1; b_val = 2;
    #1;
    check("fm_ready", 32'(in_ready), 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("fm_valid", 32'(out_valid), 0);
    check("fm_ctrl_mem", 32'(ctrl_mem), 32'h80);
    seen = 0;
    repeat (15) begin @(negedge clk); #1; seen += int'(out_valid); end
    check("fm_no_result", 32'(seen), 0);
    run_one('{mk(0, 1, 0, 1, 0, 1, 4), 32'd40, 32'd2, 32'd0, 32'd42, 32'd2, 8'hA4}, "fm_next_add");

    // Asynchronous reset in the middle of a multiply
    start_mul(32'd1234, 32'd5678);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 0);
    check("ar_d_out", d_out, 0);
    check("ar_m_wdata", m_wdata, 0);
    check("ar_ctrl_mem", 32'(ctrl_mem), 32'h80);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin @(negedge clk); #1; seen += int'(out_valid); end
    check("ar_no_result", 32'(seen), 0);
    run_one('{mk(0, 1, 1, 1, 0, 1, 5), 32'd50, 32'd8, 32'd0, 32'd42, 32'd8, 8'hA5}, "ar_next_sub");

    // Randomized traffic against an in-order scoreboard
    held = 1'b0; pd = '0; pw = '0; pc = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 7;
      ctrl_ex = 12'($urandom);
      ctrl_ex[10] = $urandom_range(0, 3) != 0;
      a_val = $urandom; b_val = $urandom; imm = $urandom;
      #1;
      if (held) begin
        check("rnd_hold_d", d_out, pd);
        check("rnd_hold_w", m_wdata, pw);
        check("rnd_hold_cm", 32'(ctrl_mem), 32'(pc));
      end
      if (out_valid && !out_ready) check("rnd_stall_ready", 32'(in_ready), 0);
      if (out_valid && out_ready) begin
        check("rnd_q_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("rnd_d", d_out, e.d);
          check("rnd_w", m_wdata, e.w);
          check("rnd_cm", 32'(ctrl_mem), 32'(e.cm));
        end
      end
      if (in_valid && in_ready) q.push_back('{ref_res(ctrl_ex, a_val, b_val, imm), b_val, ctrl_ex[7:0]});
      held = out_valid && !out_ready;
      pd = d_out; pw = m_wdata; pc = ctrl_mem;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (out_valid && q.size() != 0) begin
        e = q.pop_front();
        check("drain_d", d_out, e.d);
        check("drain_w", m_wdata, e.w);
        check("drain_cm", 32'(ctrl_mem), 32'(e.cm));
      end
      @(negedge clk);
    end
    #1;
    check("drain_q_empty", 32'(q.size()), 0);
    check("drain_idle", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
